// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO read-side stream engine.
// Holds the FSM encoding, default word type and saturating increment.
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

  localparam int unsigned WORD_W = 8;
  typedef logic [WORD_W-1:0] word_t;

  localparam int unsigned SAT_W = 32;

  function automatic logic [SAT_W-1:0] sat_inc(
    input logic [SAT_W-1:0] v,
    input logic [SAT_W-1:0] max
  );
    return (v >= max) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/stream_buf2.sv
// Two-entry in-order skid buffer; entry 0 is always the head.
// Each entry carries a data word and its end-of-packet tag.
module stream_buf2
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             last_i,
  input  logic             pop_i,
  output logic [1:0]       count_o,
  output logic             head_valid_o,
  output logic [WIDTH-1:0] head_data_o,
  output logic             head_last_o
);

  logic [WIDTH-1:0] d0_q;
  logic [WIDTH-1:0] d1_q;
  logic             l0_q;
  logic             l1_q;
  logic [1:0]       cnt_q;
  logic             do_pop;
  logic             do_push;

  assign do_pop  = pop_i && (cnt_q != 2'd0);
  assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);

  // shift on pop, write new word behind whatever survives the pop
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      d0_q  <= '0;
      d1_q  <= '0;
      l0_q  <= 1'b0;
      l1_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            d0_q <= data_i;
            l0_q <= last_i;
          end else begin
            d1_q <= data_i;
            l1_q <= last_i;
          end
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          d0_q  <= d1_q;
          l0_q  <= l1_q;
          cnt_q <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            d0_q <= data_i;
            l0_q <= last_i;
          end else begin
            d0_q <= d1_q;
            l0_q <= l1_q;
            d1_q <= data_i;
            l1_q <= last_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign count_o      = cnt_q;
  assign head_valid_o = (cnt_q != 2'd0);
  assign head_data_o  = d0_q;
  assign head_last_o  = l0_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a 1-cycle-latency FIFO read port into a framed valid/ready stream.
// Keeps at most two words held or in flight, full rate under steady ready.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int PKT_LEN   = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic                 empty_i,
  output logic                 rd_en_o,
  input  logic [WIDTH-1:0]     rdata_i,
  input  logic                 rd_error_i,
  output logic [WIDTH-1:0]     m_data_o,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic                 m_last_o,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] word_cnt_o,
  output logic [CNT_WIDTH-1:0] err_cnt_o
);

  localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BW-1:0] BEAT_MAX = BW'(PKT_LEN - 1);
  localparam logic [31:0] PKT_W  = 32'(PKT_LEN);
  localparam logic [31:0] LAST_W = 32'(PKT_LEN - 1);
  localparam logic [31:0] CNT_MAX = 32'({CNT_WIDTH{1'b1}});

  state_e               state_q;
  logic                 busy_q;
  logic                 inflight_q;
  logic [BW-1:0]        beat_q;
  logic [CNT_WIDTH-1:0] word_q;
  logic [CNT_WIDTH-1:0] err_q;

  logic [1:0]       count;
  logic             head_valid;
  logic             head_last;
  logic [WIDTH-1:0] head_data;
  logic             pop;
  logic             push;
  logic             drop;
  logic [2:0]       held;
  logic [2:0]       limit;
  logic [31:0]      pos;
  logic             tag_last;

  assign pop  = head_valid && m_ready_i;
  assign push = inflight_q && !rd_error_i;
  assign drop = inflight_q && rd_error_i;

  assign held  = {1'b0, count} + {2'b00, inflight_q};
  assign limit = 3'd2 + {2'b00, pop};

  assign rd_en_o = !rst_i
                && (state_q == RUN)
                && !empty_i
                && (held < limit);

  // a word pushed now lands at stream position beat + count
  assign pos      = 32'(beat_q) + 32'(count);
  assign tag_last = ((pos % PKT_W) == LAST_W);

  stream_buf2 #(
    .WIDTH(WIDTH)
  ) u_buf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .data_i      (rdata_i),
    .last_i      (tag_last),
    .pop_i       (pop),
    .count_o     (count),
    .head_valid_o(head_valid),
    .head_data_o (head_data),
    .head_last_o (head_last)
  );

  // read data returns one cycle after the strobe
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= rd_en_o;
    end
  end

  // run/stop control; busy tracks every non-idle state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable_i) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (!enable_i) begin
            state_q <= STOP;
          end
        end
        STOP: begin
          if (enable_i) begin
            state_q <= RUN;
          end else if (!inflight_q && (count == 2'd0)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // framing beat, delivered-word and dropped-read counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      beat_q <= '0;
      word_q <= '0;
      err_q  <= '0;
    end else begin
      if (pop) begin
        beat_q <= (beat_q == BEAT_MAX) ? '0 : beat_q + 1'b1;
        word_q <= word_q + 1'b1;
      end
      if (drop) begin
        err_q <= CNT_WIDTH'(sat_inc(32'(err_q), CNT_MAX));
      end
    end
  end

  assign m_valid_o  = head_valid;
  assign m_data_o   = head_data;
  assign m_last_o   = head_valid && head_last;
  assign busy_o     = busy_q;
  assign word_cnt_o = word_q;
  assign err_cnt_o  = err_q;

endmodule
